// File: rtl/rv_pkg.sv
// rv_pkg: shared R-type opcode/funct constants, ALU control codes and instruction decode helper.
// Used by rtype_issue_stage and the downstream ALU so both agree on the control encoding.
package rv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0100,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b0011
    } alu_ctrl_e;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef struct packed {
        logic      legal;
        logic      shift;
        alu_ctrl_e ctrl;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        opc     = instr[6:0];
        f3      = instr[14:12];
        f7      = instr[31:25];
        d.legal = 1'b0;
        d.shift = 1'b0;
        d.ctrl  = ALU_ADD;
        if (opc == OPC_RTYPE && f7 == F7_BASE) begin
            d.legal = 1'b1;
            case (f3)
                F3_ADD_SUB: d.ctrl = ALU_ADD;
                F3_AND:     d.ctrl = ALU_AND;
                F3_OR:      d.ctrl = ALU_OR;
                F3_SLL:     begin d.ctrl = ALU_SLL; d.shift = 1'b1; end
                F3_SRL:     begin d.ctrl = ALU_SRL; d.shift = 1'b1; end
                default:    d.legal = 1'b0;
            endcase
        end else if (opc == OPC_RTYPE && f7 == F7_SUB && f3 == F3_ADD_SUB) begin
            d.legal = 1'b1;
            d.ctrl  = ALU_SUB;
        end
        return d;
    endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: NREG x XLEN register file, two async read ports, one sync write port.
// Ports: clk, rst (sync, active-high, clears all entries), we/waddr/wdata write port,
// raddr1/rdata1 and raddr2/rdata2 read ports. A same-cycle write is forwarded to the
// read ports; register 0 always reads zero and ignores writes.
module reg_file_2r1w #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [XLEN-1:0]         wdata,
    input  logic [$clog2(NREG)-1:0] raddr1,
    input  logic [$clog2(NREG)-1:0] raddr2,
    output logic [XLEN-1:0]         rdata1,
    output logic [XLEN-1:0]         rdata2
);

    logic [XLEN-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : (we && waddr == raddr1) ? wdata : mem[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : (we && waddr == raddr2) ? wdata : mem[raddr2];

endmodule

// File: rtl/rtype_issue_stage.sv
// rtype_issue_stage: decode/issue stage feeding the R-type ALU with a RAW scoreboard.
// Ports: clk, rst (sync, active-high); fetch side if_valid/if_instr/if_ready;
// ALU side ex_valid/ex_ready/ex_a/ex_b/ex_alu_ctrl/ex_rd; writeback wb_en/wb_rd/wb_data;
// flush drops the held ID/EX entry; illegal pulses for one cycle per discarded instruction.
module rtype_issue_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    output logic            if_ready,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [3:0]      ex_alu_ctrl,
    output logic [4:0]      ex_rd,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            illegal
);

    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rdata1, rdata2;
    logic [NREG-1:0] busy, wb_clr, flush_clr, issue_set;
    logic            hazard, accept, issue;
    dec_t            dec;

    assign rs1 = if_instr[19:15];
    assign rs2 = if_instr[24:20];
    assign rd  = if_instr[11:7];
    assign dec = decode(if_instr);

    reg_file_2r1w #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_en),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    // A register being written back this cycle is no longer pending, and its
    // value reaches the operand through the register file's write-through path.
    assign wb_clr    = (wb_en && wb_rd != '0) ? ONE << wb_rd : '0;
    assign flush_clr = (flush && ex_valid) ? ONE << ex_rd : '0;
    assign issue_set = (issue && rd != '0) ? ONE << rd : '0;
    assign hazard    = (busy[rs1] & ~wb_clr[rs1]) | (busy[rs2] & ~wb_clr[rs2]);

    assign if_ready = !rst && !flush && (!ex_valid || ex_ready) && !(dec.legal && hazard);
    assign accept   = if_valid && if_ready;
    assign issue    = accept && dec.legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            ex_valid    <= 1'b0;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_alu_ctrl <= ALU_ADD;
            ex_rd       <= '0;
            illegal     <= 1'b0;
        end else begin
            // Clears first so a same-cycle issue to the same register keeps its bit.
            busy     <= (busy & ~wb_clr & ~flush_clr) | issue_set;
            ex_valid <= !flush && (issue || (ex_valid && !ex_ready));
            illegal  <= accept && !dec.legal;
            if (issue) begin
                ex_a        <= rdata1;
                ex_b        <= dec.shift ? {{(XLEN-5){1'b0}}, rdata2[4:0]} : rdata2;
                ex_alu_ctrl <= dec.ctrl;
                ex_rd       <= rd;
            end
        end
    end

endmodule

// File: tb/tb_rtype_issue_stage.sv
// tb_rtype_issue_stage: directed table-driven and sequence checks for rtype_issue_stage.
module tb_rtype_issue_stage;

    logic        clk = 1'b0;
    logic        rst, if_valid, if_ready, ex_valid, ex_ready, wb_en, flush, illegal;
    logic [31:0] if_instr, ex_a, ex_b, wb_data;
    logic [3:0]  ex_alu_ctrl;
    logic [4:0]  ex_rd, wb_rd;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    rtype_issue_stage dut (
        .clk         (clk),
        .rst         (rst),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_ready    (if_ready),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_a        (ex_a),
        .ex_b        (ex_b),
        .ex_alu_ctrl (ex_alu_ctrl),
        .ex_rd       (ex_rd),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flush       (flush),
        .illegal     (illegal)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        legal;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
    } vec_t;

    vec_t vt[12];

    function automatic logic [31:0] rt(input logic [6:0] f7, input logic [4:0] r2,
                                       input logic [4:0] r1, input logic [2:0] f3,
                                       input logic [4:0] d);
        return {f7, r2, r1, f3, d, 7'b0110011};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_rd   = r;
        wb_data = d;
        tick();
        wb_en   = 1'b0;
    endtask

    initial begin
        vt[0]  = '{"add",   rt(7'h00, 5'd2,  5'd1,  3'b000, 5'd0), 1'b1, 32'h5,        32'h3,        4'b0000};
        vt[1]  = '{"sub",   rt(7'h20, 5'd1,  5'd2,  3'b000, 5'd0), 1'b1, 32'h3,        32'h5,        4'b0001};
        vt[2]  = '{"and",   rt(7'h00, 5'd10, 5'd9,  3'b111, 5'd0), 1'b1, 32'hF0,       32'h0F0F0F0F, 4'b0010};
        vt[3]  = '{"or",    rt(7'h00, 5'd10, 5'd9,  3'b110, 5'd0), 1'b1, 32'hF0,       32'h0F0F0F0F, 4'b0100};
        vt[4]  = '{"sll",   rt(7'h00, 5'd6,  5'd1,  3'b001, 5'd0), 1'b1, 32'h5,        32'h2,        4'b1000};
        vt[5]  = '{"srl",   rt(7'h00, 5'd6,  5'd10, 3'b101, 5'd0), 1'b1, 32'h0F0F0F0F, 32'h2,        4'b0011};
        vt[6]  = '{"sll_m", rt(7'h00, 5'd9,  5'd1,  3'b001, 5'd0), 1'b1, 32'h5,        32'h10,       4'b1000};
        vt[7]  = '{"x0rd",  rt(7'h00, 5'd1,  5'd0,  3'b000, 5'd0), 1'b1, 32'h0,        32'h5,        4'b0000};
        vt[8]  = '{"mul",   rt(7'h01, 5'd2,  5'd1,  3'b000, 5'd0), 1'b0, 32'h0,        32'h0,        4'b0000};
        vt[9]  = '{"addi",  {12'h005, 5'd1, 3'b000, 5'd0, 7'b0010011}, 1'b0, 32'h0,  32'h0,        4'b0000};
        vt[10] = '{"sra",   rt(7'h20, 5'd6,  5'd1,  3'b101, 5'd0), 1'b0, 32'h0,        32'h0,        4'b0000};
        vt[11] = '{"slt",   rt(7'h00, 5'd2,  5'd1,  3'b010, 5'd0), 1'b0, 32'h0,        32'h0,        4'b0000};

        rst = 1'b1; if_valid = 1'b0; if_instr = '0; ex_ready = 1'b1;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
        tick();
        tick();
        chk("rst_if_ready", 32'(if_ready), 32'h0);
        chk("rst_ex_valid", 32'(ex_valid), 32'h0);
        chk("rst_ex_a", ex_a, 32'h0);
        chk("rst_ex_b", ex_b, 32'h0);
        chk("rst_ctrl", 32'(ex_alu_ctrl), 32'h0);
        chk("rst_rd", 32'(ex_rd), 32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);
        chk("rst_busy", dut.busy, 32'h0);
        rst = 1'b0;

        wb(5'd1, 32'h5);
        wb(5'd2, 32'h3);
        wb(5'd6, 32'hFFFFFF22);
        wb(5'd9, 32'hF0);
        wb(5'd10, 32'h0F0F0F0F);
        wb(5'd0, 32'hDEAD);

        // Decode table, one instruction at a time with the ALU always ready.
        for (int i = 0; i < 12; i++) begin
            if_valid = 1'b1;
            if_instr = vt[i].instr;
            #1;
            chk({vt[i].name, "_ready"}, 32'(if_ready), 32'h1);
            tick();
            if_valid = 1'b0;
            chk({vt[i].name, "_valid"}, 32'(ex_valid), 32'(vt[i].legal));
            chk({vt[i].name, "_illegal"}, 32'(illegal), 32'(!vt[i].legal));
            if (vt[i].legal) begin
                chk({vt[i].name, "_a"}, ex_a, vt[i].a);
                chk({vt[i].name, "_b"}, ex_b, vt[i].b);
                chk({vt[i].name, "_ctrl"}, 32'(ex_alu_ctrl), 32'(vt[i].ctrl));
            end
            tick();
            chk({vt[i].name, "_idle_valid"}, 32'(ex_valid), 32'h0);
            chk({vt[i].name, "_idle_illegal"}, 32'(illegal), 32'h0);
        end

        // ADD x3,x1,x2 then dependent SUB x4,x3,x1 released by writeback bypass.
        if_valid = 1'b1; if_instr = 32'h002081B3; ex_ready = 1'b0;
        #1;
        chk("add3_ready", 32'(if_ready), 32'h1);
        tick();
        chk("add3_valid", 32'(ex_valid), 32'h1);
        chk("add3_a", ex_a, 32'h5);
        chk("add3_b", ex_b, 32'h3);
        chk("add3_ctrl", 32'(ex_alu_ctrl), 32'h0);
        chk("add3_rd", 32'(ex_rd), 32'h3);
        chk("add3_busy3", 32'(dut.busy[3]), 32'h1);
        if_instr = rt(7'h20, 5'd1, 5'd3, 3'b000, 5'd4);
        ex_ready = 1'b1;
        #1;
        chk("raw_stall", 32'(if_ready), 32'h0);
        tick();
        chk("raw_consumed", 32'(ex_valid), 32'h0);
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h8;
        #1;
        chk("raw_release", 32'(if_ready), 32'h1);
        tick();
        wb_en = 1'b0;
        chk("sub4_valid", 32'(ex_valid), 32'h1);
        chk("sub4_a", ex_a, 32'h8);
        chk("sub4_b", ex_b, 32'h5);
        chk("sub4_ctrl", 32'(ex_alu_ctrl), 32'h1);
        chk("sub4_rd", 32'(ex_rd), 32'h4);
        chk("sub4_busy3", 32'(dut.busy[3]), 32'h0);
        chk("sub4_busy4", 32'(dut.busy[4]), 32'h1);

        // Backpressure: outputs hold for three cycles, then back-to-back issue.
        ex_ready = 1'b0;
        if_instr = rt(7'h00, 5'd2, 5'd1, 3'b000, 5'd0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("hold_ready", 32'(if_ready), 32'h0);
            tick();
            chk("hold_valid", 32'(ex_valid), 32'h1);
            chk("hold_a", ex_a, 32'h8);
            chk("hold_b", ex_b, 32'h5);
            chk("hold_ctrl", 32'(ex_alu_ctrl), 32'h1);
        end
        ex_ready = 1'b1;
        #1;
        chk("b2b_ready", 32'(if_ready), 32'h1);
        tick();
        if_valid = 1'b0;
        chk("b2b_valid", 32'(ex_valid), 32'h1);
        chk("b2b_a", ex_a, 32'h5);
        chk("b2b_b", ex_b, 32'h3);
        chk("b2b_ctrl", 32'(ex_alu_ctrl), 32'h0);
        tick();
        chk("b2b_drain", 32'(ex_valid), 32'h0);
        wb(5'd4, 32'h0);

        // Issue to x12 while x12 is written back: the new busy bit survives.
        if_valid = 1'b1; if_instr = rt(7'h00, 5'd2, 5'd1, 3'b000, 5'd12);
        wb_en = 1'b1; wb_rd = 5'd12; wb_data = 32'h7;
        tick();
        wb_en = 1'b0; if_valid = 1'b0;
        chk("setwins_busy12", 32'(dut.busy[12]), 32'h1);
        tick();
        if_valid = 1'b1; if_instr = rt(7'h00, 5'd12, 5'd1, 3'b000, 5'd0);
        #1;
        chk("setwins_stall", 32'(if_ready), 32'h0);
        if_valid = 1'b0;
        wb(5'd12, 32'h7);

        // Flush a held ADD x7: entry dropped and its busy bit released.
        if_valid = 1'b1; if_instr = rt(7'h00, 5'd2, 5'd1, 3'b000, 5'd7); ex_ready = 1'b0;
        tick();
        chk("fl_valid", 32'(ex_valid), 32'h1);
        chk("fl_busy7", 32'(dut.busy[7]), 32'h1);
        flush = 1'b1; if_instr = rt(7'h00, 5'd1, 5'd7, 3'b000, 5'd0);
        #1;
        chk("fl_ready", 32'(if_ready), 32'h0);
        tick();
        flush = 1'b0;
        chk("fl_dropped", 32'(ex_valid), 32'h0);
        chk("fl_busy7_clr", 32'(dut.busy[7]), 32'h0);
        chk("busy0", 32'(dut.busy[0]), 32'h0);
        #1;
        chk("fl_after_ready", 32'(if_ready), 32'h1);
        tick();
        if_valid = 1'b0; ex_ready = 1'b1;
        chk("fl_after_valid", 32'(ex_valid), 32'h1);
        chk("fl_after_a", ex_a, 32'h0);
        chk("fl_after_b", ex_b, 32'h5);
        tick();

        // Reset mid-stream clears outputs, scoreboard and register contents.
        if_valid = 1'b1; if_instr = rt(7'h00, 5'd2, 5'd1, 3'b000, 5'd13); ex_ready = 1'b0;
        tick();
        chk("mr_valid", 32'(ex_valid), 32'h1);
        chk("mr_busy13", 32'(dut.busy[13]), 32'h1);
        if_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_ex_valid", 32'(ex_valid), 32'h0);
        chk("mr_ex_a", ex_a, 32'h0);
        chk("mr_ex_b", ex_b, 32'h0);
        chk("mr_ctrl", 32'(ex_alu_ctrl), 32'h0);
        chk("mr_rd", 32'(ex_rd), 32'h0);
        chk("mr_busy", dut.busy, 32'h0);
        if_valid = 1'b1; if_instr = rt(7'h00, 5'd2, 5'd1, 3'b000, 5'd0); ex_ready = 1'b1;
        tick();
        if_valid = 1'b0;
        chk("mr_regs_valid", 32'(ex_valid), 32'h1);
        chk("mr_regs_a", ex_a, 32'h0);
        chk("mr_regs_b", ex_b, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
